// File: rtl/invader_hit_detect_pkg.sv
// Shared geometry defaults, coordinate type and FSM encoding for the invader hit detector.
// Also used by the hit-box compare that is later reused for bomb-vs-player checks.
package invader_hit_detect_pkg;
  localparam int N_INVADERS_DEF  = 6;
  localparam int INV_W_DEF       = 32;
  localparam int INV_H_DEF       = 32;
  localparam int INV_SPACING_DEF = 48;
  localparam int ROW_Y_DEF       = 64;
  localparam int PROJ_W_DEF      = 4;
  localparam int PROJ_H_DEF      = 16;
  localparam int POINTS_DEF      = 10;
  localparam int SCORE_W_DEF     = 14;

  // One bit wider than screen coordinates so edge sums never wrap.
  localparam int COORD_W = 11;
  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_COMMIT = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  function automatic coord_t widen(input logic [9:0] v);
    return {1'b0, v};
  endfunction
endpackage

// File: rtl/invader_hit_detect_hit_box_overlap.sv
// Combinational axis-aligned bounding-box overlap test between box a and box b.
// Boxes that merely touch along an edge do not overlap.
module hit_box_overlap
  import invader_hit_detect_pkg::*;
(
  input  coord_t a_x,
  input  coord_t a_y,
  input  coord_t a_w,
  input  coord_t a_h,
  input  coord_t b_x,
  input  coord_t b_y,
  input  coord_t b_w,
  input  coord_t b_h,
  output logic   hit
);
  assign hit = (a_x < b_x + b_w) && (a_x + a_w > b_x) &&
               (a_y < b_y + b_h) && (a_y + a_h > b_y);
endmodule

// File: rtl/invader_hit_detect.sv
// Per-frame laser vs invader-row collision check, one invader per cycle through a shared
// box compare; owns the alive mask and the saturating score.
module invader_hit_detect
  import invader_hit_detect_pkg::*;
#(
  parameter int N_INVADERS  = N_INVADERS_DEF,
  parameter int INV_W       = INV_W_DEF,
  parameter int INV_H       = INV_H_DEF,
  parameter int INV_SPACING = INV_SPACING_DEF,
  parameter int ROW_Y       = ROW_Y_DEF,
  parameter int PROJ_W      = PROJ_W_DEF,
  parameter int PROJ_H      = PROJ_H_DEF,
  parameter int POINTS      = POINTS_DEF,
  parameter int SCORE_W     = SCORE_W_DEF
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame,
  input  logic                  restart,
  input  logic                  laser_active,
  input  logic [9:0]            laser_x,
  input  logic [9:0]            laser_y,
  input  logic [9:0]            invaders_x,
  output logic [N_INVADERS-1:0] invader_collision,
  output logic [N_INVADERS-1:0] alive,
  output logic [SCORE_W-1:0]    score,
  output logic                  hit_pulse,
  output logic                  all_dead,
  output logic                  busy
);
  localparam int                 IDX_W     = (N_INVADERS > 1) ? $clog2(N_INVADERS) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(N_INVADERS - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  state_t                  state_reg, state_next;
  logic [IDX_W-1:0]        idx_reg, hit_idx_reg;
  logic                    hit_found_reg;
  coord_t                  lx_reg, ly_reg, ix0_reg, cur_ix;
  logic [N_INVADERS-1:0]   collision_reg, alive_reg, hit_onehot;
  logic [SCORE_W-1:0]      score_reg, score_next;
  logic [SCORE_W:0]        score_sum;
  logic                    hit_pulse_reg;
  logic                    box_hit, cur_hit;
  logic                    capture, scan_step, do_kill, hold_release;

  assign cur_ix = ix0_reg + coord_t'(idx_reg) * coord_t'(INV_SPACING);

  hit_box_overlap u_overlap (
    .a_x (lx_reg),
    .a_y (ly_reg),
    .a_w (coord_t'(PROJ_W)),
    .a_h (coord_t'(PROJ_H)),
    .b_x (cur_ix),
    .b_y (coord_t'(ROW_Y)),
    .b_w (coord_t'(INV_W)),
    .b_h (coord_t'(INV_H)),
    .hit (box_hit)
  );

  assign cur_hit = box_hit && alive_reg[idx_reg];

  for (genvar gi = 0; gi < N_INVADERS; gi++) begin : g_onehot
    assign hit_onehot[gi] = (hit_idx_reg == IDX_W'(gi));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (frame && laser_active) state_next = ST_SCAN;
      ST_SCAN:   if (idx_reg == LAST_IDX) state_next = ST_COMMIT;
      ST_COMMIT: state_next = hit_found_reg ? ST_HOLD : ST_IDLE;
      ST_HOLD:   if (!laser_active) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
    if (restart) state_next = ST_IDLE;
  end

  always_comb begin
    capture      = 1'b0;
    scan_step    = 1'b0;
    do_kill      = 1'b0;
    hold_release = 1'b0;
    case (state_reg)
      ST_IDLE:   capture      = frame && laser_active;
      ST_SCAN:   scan_step    = 1'b1;
      ST_COMMIT: do_kill      = hit_found_reg && !restart;
      ST_HOLD:   hold_release = !laser_active;
      default:   ;
    endcase
  end

  // Saturate rather than wrap so a long game never rolls the score back to zero.
  always_comb begin
    score_sum  = {1'b0, score_reg} + (SCORE_W+1)'(POINTS);
    score_next = (score_sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : score_sum[SCORE_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_reg       <= '0;
      hit_idx_reg   <= '0;
      hit_found_reg <= 1'b0;
      lx_reg        <= '0;
      ly_reg        <= '0;
      ix0_reg       <= '0;
      collision_reg <= '0;
      alive_reg     <= '1;
      score_reg     <= '0;
      hit_pulse_reg <= 1'b0;
    end else begin
      hit_pulse_reg <= do_kill;
      if (restart) begin
        alive_reg     <= '1;
        collision_reg <= '0;
      end else if (do_kill) begin
        collision_reg <= hit_onehot;
        alive_reg     <= alive_reg & ~hit_onehot;
        score_reg     <= score_next;
      end else if (hold_release) begin
        collision_reg <= '0;
      end
      if (capture) begin
        lx_reg        <= widen(laser_x);
        ly_reg        <= widen(laser_y);
        ix0_reg       <= widen(invaders_x);
        idx_reg       <= '0;
        hit_found_reg <= 1'b0;
      end
      if (scan_step) begin
        idx_reg <= idx_reg + IDX_W'(1);
        // Only the lowest-index hit of a scan is kept.
        if (cur_hit && !hit_found_reg) begin
          hit_found_reg <= 1'b1;
          hit_idx_reg   <= idx_reg;
        end
      end
    end
  end

  assign invader_collision = collision_reg;
  assign alive             = alive_reg;
  assign score             = score_reg;
  assign hit_pulse         = hit_pulse_reg;
  assign all_dead          = (alive_reg == '0);
  assign busy              = (state_reg != ST_IDLE);
endmodule

// File: tb/tb_invader_hit_detect.sv
// Self-checking bench: directed table, multi-cycle corner sequences and random shots
// against a frame-level reference model of the invader row.
module tb_invader_hit_detect;
  localparam int N       = 6;
  localparam int IW      = 32;
  localparam int IH      = 32;
  localparam int SP      = 48;
  localparam int RY      = 64;
  localparam int PW      = 4;
  localparam int PW_WIDE = 20;
  localparam int PH      = 16;
  localparam int PTS     = 10;
  localparam int SMAX    = 16383;

  logic        clk = 1'b0;
  logic        rst_n, frame, restart, laser_active;
  logic [9:0]  laser_x, laser_y, invaders_x;
  logic [5:0]  coll, alive;
  logic [13:0] score;
  logic        hit_pulse, all_dead, busy;
  logic [5:0]  w_coll, w_alive;
  logic [13:0] w_score;
  logic        w_pulse, w_dead, w_busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [5:0] m_alive, w_m_alive;
  int m_score;

  always #5 clk = ~clk;

  invader_hit_detect dut (
    .clk(clk), .rst_n(rst_n), .frame(frame), .restart(restart), .laser_active(laser_active),
    .laser_x(laser_x), .laser_y(laser_y), .invaders_x(invaders_x),
    .invader_collision(coll), .alive(alive), .score(score), .hit_pulse(hit_pulse),
    .all_dead(all_dead), .busy(busy)
  );

  invader_hit_detect #(.PROJ_W(PW_WIDE)) dut_wide (
    .clk(clk), .rst_n(rst_n), .frame(frame), .restart(restart), .laser_active(laser_active),
    .laser_x(laser_x), .laser_y(laser_y), .invaders_x(invaders_x),
    .invader_collision(w_coll), .alive(w_alive), .score(w_score), .hit_pulse(w_pulse),
    .all_dead(w_dead), .busy(w_busy)
  );

  typedef struct {
    int lx;
    int ly;
    int ix;
    int exp_coll;
    int exp_wide;   // -1: take the wide-laser expectation from the model
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Lowest-index live invader whose box overlaps the laser box, or -1.
  function automatic int model_hit(input int lx, input int ly, input int ix,
                                   input logic [5:0] al, input int pw);
    for (int i = 0; i < N; i++) begin
      int x0;
      x0 = ix + i * SP;
      if (al[i] && lx < x0 + IW && lx + pw > x0 && ly < RY + IH && ly + PH > RY)
        return i;
    end
    return -1;
  endfunction

  task automatic do_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    m_alive   = '1;
    w_m_alive = '1;
    check("restart_alive", 32'(alive), 32'h3f);
    check("restart_score", 32'(score), 32'(m_score));
  endtask

  // One laser shot from frame pulse through laser retirement.
  task automatic shot(input int lx, input int ly, input int ix, input bit drop_early,
                      input bit restart_commit, input int hold, input int exp_tbl,
                      input int exp_wide_tbl);
    int mh, wh, exp_coll, exp_wide;
    mh = model_hit(lx, ly, ix, m_alive, PW);
    wh = model_hit(lx, ly, ix, w_m_alive, PW_WIDE);
    laser_x      = 10'(lx);
    laser_y      = 10'(ly);
    invaders_x   = 10'(ix);
    laser_active = 1'b1;
    frame        = 1'b1;
    tick();                                   // E0
    frame = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      if (drop_early && k == 3) laser_active = 1'b0;
      if (k == 4) frame = 1'b1;               // ignored while scanning
      if (k == 5) frame = 1'b0;
      tick();
    end
    if (restart_commit) restart = 1'b1;
    tick();                                   // E7
    restart = 1'b0;
    if (restart_commit) begin
      mh = -1; wh = -1;
      m_alive = '1; w_m_alive = '1;
    end else begin
      if (mh >= 0) begin
        m_alive[mh] = 1'b0;
        m_score = (m_score + PTS > SMAX) ? SMAX : m_score + PTS;
      end
      if (wh >= 0) w_m_alive[wh] = 1'b0;
    end
    exp_coll = (exp_tbl >= 0 && !restart_commit) ? exp_tbl : ((mh >= 0) ? (1 << mh) : 0);
    exp_wide = (exp_wide_tbl >= 0) ? exp_wide_tbl : ((wh >= 0) ? (1 << wh) : 0);
    $display("shot lx=%0d ly=%0d ix=%0d coll=%b alive=%b score=%0d pulse=%b",
             lx, ly, ix, coll, alive, score, hit_pulse);
    check("collision", 32'(coll), 32'(exp_coll));
    check("alive", 32'(alive), 32'(m_alive));
    check("score", 32'(score), 32'(m_score));
    check("hit_pulse", 32'(hit_pulse), 32'(mh >= 0));
    check("all_dead", 32'(all_dead), 32'(m_alive == 0));
    check("wide_collision", 32'(w_coll), 32'(exp_wide));
    for (int k = 0; k < hold; k++) tick();
    if (hold > 0) begin
      check("held_collision", 32'(coll), 32'(exp_coll));
      check("held_busy", 32'(busy), 32'(mh >= 0));
    end
    laser_active = 1'b0;
    tick();
    check("retired_collision", 32'(coll), 32'h0);
    check("retired_busy", 32'(busy), 32'h0);
    check("pulse_single", 32'(hit_pulse), 32'h0);
  endtask

  vec_t vecs[13];

  initial begin
    rst_n = 1'b0; frame = 1'b0; restart = 1'b0; laser_active = 1'b0;
    laser_x = '0; laser_y = '0; invaders_x = '0;
    m_alive = '1; w_m_alive = '1; m_score = 0;

    vecs[0]  = '{150, 80, 100, 6'b000010, -1};
    vecs[1]  = '{130, 80, 100, 6'b000001, 6'b000001};  // straddles 0 and 1 with wide laser
    vecs[2]  = '{150,  0, 100, 0, -1};
    vecs[3]  = '{150, 96, 100, 0, -1};                 // top at row bottom edge
    vecs[4]  = '{150, 95, 100, 6'b000010, -1};
    vecs[5]  = '{150, 48, 100, 0, -1};                 // bottom at row top edge
    vecs[6]  = '{150, 49, 100, 6'b000010, -1};
    vecs[7]  = '{ 96, 80, 100, 0, -1};
    vecs[8]  = '{ 97, 80, 100, 6'b000001, -1};
    vecs[9]  = '{131, 80, 100, 6'b000001, -1};
    vecs[10] = '{132, 80, 100, 0, -1};
    vecs[11] = '{1021, 80, 990, 6'b000001, -1};
    vecs[12] = '{1022, 80, 990, 0, -1};

    // Reset
    tick(); tick();
    check("reset_collision", 32'(coll), 32'h0);
    check("reset_alive", 32'(alive), 32'h3f);
    check("reset_score", 32'(score), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_pulse", 32'(hit_pulse), 32'h0);
    rst_n = 1'b1;
    tick();

    // Kill the whole row, then re-arm keeping the score
    for (int i = 0; i < N; i++) shot(100 + i * SP + 10, 80, 100, 1'b0, 1'b0, 0, -1, -1);
    check("all_dead_set", 32'(all_dead), 32'h1);
    check("score_60", 32'(score), 32'd60);
    do_restart();
    check("all_dead_clear", 32'(all_dead), 32'h0);

    // Basic hit held 20 cycles, then same shot with invader 1 dead
    shot(150, 80, 100, 1'b0, 1'b0, 20, 6'b000010, -1);
    shot(150, 80, 100, 1'b0, 1'b0, 0, 0, -1);
    check("dead_busy", 32'(busy), 32'h0);

    // A frame with the laser off does nothing
    frame = 1'b1; laser_active = 1'b0; tick(); frame = 1'b0;
    check("no_laser_busy", 32'(busy), 32'h0);

    // Directed table, each vector against a fully armed row
    for (int v = 0; v < 13; v++) begin
      do_restart();
      shot(vecs[v].lx, vecs[v].ly, vecs[v].ix, 1'b0, 1'b0, 0, vecs[v].exp_coll, vecs[v].exp_wide);
    end

    // Restart in the COMMIT cycle cancels the kill
    do_restart();
    shot(150, 80, 100, 1'b0, 1'b1, 0, -1, -1);

    // Laser drops mid-scan: hit still reported, released the next cycle
    shot(150, 80, 100, 1'b1, 1'b0, 0, 6'b000010, -1);

    // Random shots against the model
    for (int r = 0; r < 200; r++) begin
      int ix, lx, ly;
      if (m_alive == 0 || $urandom_range(0, 15) == 0) do_restart();
      ix = $urandom_range(0, 700);
      lx = ix - 20 + $urandom_range(0, 320);
      if (lx > 1023) lx = 1023;
      ly = $urandom_range(40, 110);
      shot(lx, ly, ix, ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0), 0, -1, -1);
    end

    // Reset in the middle of a scan aborts cleanly
    laser_x = 10'd150; laser_y = 10'd80; invaders_x = 10'd100;
    laser_active = 1'b1; frame = 1'b1; tick(); frame = 1'b0;
    tick(); tick();
    rst_n = 1'b0; tick();
    rst_n = 1'b1; laser_active = 1'b0;
    m_alive = '1; w_m_alive = '1; m_score = 0;
    for (int k = 0; k < 8; k++) tick();
    check("midscan_collision", 32'(coll), 32'h0);
    check("midscan_alive", 32'(alive), 32'h3f);
    check("midscan_score", 32'(score), 32'h0);
    check("midscan_busy", 32'(busy), 32'h0);

    // Drive the score into saturation
    while (m_score < SMAX) begin
      int t;
      if (m_alive == 0) do_restart();
      t = 0;
      while (!m_alive[t]) t++;
      shot(100 + t * SP + 10, 80, 100, 1'b0, 1'b0, 0, -1, -1);
    end
    for (int k = 0; k < 2; k++) begin
      int t;
      if (m_alive == 0) do_restart();
      t = 0;
      while (!m_alive[t]) t++;
      shot(100 + t * SP + 10, 80, 100, 1'b0, 1'b0, 0, -1, -1);
    end
    check("score_saturated", 32'(score), 32'd16383);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
